// File: rtl/rtcl_p3s7_word_align.sv
// Word aligner: finds the training pattern at any of ten bit offsets in a 10-bit stream and locks onto it.
// Define RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN to enable the search timeout and the ERROR state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RESET  | aligner cleared; the pattern is latched when in_align_reset drops
// ST_SEARCH | scanning valid words for LOCK_COUNT consecutive hits at one offset
// ST_LOCKED | offset frozen; aligned words are forwarded on m_data/m_valid
// ST_ERROR  | search timed out; held here until in_align_reset
module rtcl_p3s7_word_align #(
   parameter int unsigned LOCK_COUNT    = 16,
   parameter int unsigned TIMEOUT_WORDS = 65535
) (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic       in_align_reset,
   input  logic [9:0] in_align_pattern,
   input  logic [9:0] s_data,
   input  logic       s_valid,
   output logic [9:0] m_data,
   output logic       m_valid,
   output logic       out_align_done,
   output logic       out_align_error
);

   typedef enum logic [1:0] {ST_RESET, ST_SEARCH, ST_LOCKED, ST_ERROR} state_t;

   localparam logic [7:0] LOCK_CNT = 8'(LOCK_COUNT);

   if (LOCK_COUNT < 1 || LOCK_COUNT > 255) begin : g_bad_lock_count
      $error("LOCK_COUNT must be in 1..255");
   end
   if (TIMEOUT_WORDS < 1 || TIMEOUT_WORDS > 24'hff_ffff) begin : g_bad_timeout
      $error("TIMEOUT_WORDS must be in 1..2^24-1");
   end

   state_t      state_q, state_d;
   logic [9:0]  prev_q;
   logic [9:0]  pattern_q, pattern_d;
   logic [3:0]  offset_q, offset_d;
   logic [7:0]  count_q, count_d;
   logic [9:0]  m_data_q;
   logic        sv_q;
   logic        done_q;

   logic [19:0] win;
   logic [9:0]  match;
   logic        any_hit;
   logic [3:0]  first_k;
   logic [9:0]  win_sel;

`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
   localparam logic [23:0] TMO_LIM = 24'(TIMEOUT_WORDS);
   logic [23:0] tmo_q, tmo_d;
   logic        error_q;
`endif

   assign win = {s_data, prev_q};

   always_comb begin
      match   = '0;
      first_k = '0;
      for (int k = 0; k < 10; k++) begin
         match[k] = (10'(win >> k) == pattern_q);
      end
      for (int k = 9; k >= 0; k--) begin
         if (match[k]) first_k = 4'(k);
      end
      any_hit = |match;
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      offset_d  = offset_q;
      count_d   = count_q;
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
      tmo_d     = tmo_q;
`endif
      unique case (state_q)
         ST_RESET: begin
            offset_d = '0;
            count_d  = '0;
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
            tmo_d    = '0;
`endif
            if (!in_align_reset) begin
               pattern_d = in_align_pattern;
               state_d   = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (s_valid) begin
               if (match[offset_q]) begin
                  count_d = count_q + 8'd1;
               end else if (any_hit) begin
                  offset_d = first_k;
                  count_d  = 8'd1;
               end else begin
                  count_d = '0;
               end
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
               tmo_d = tmo_q + 24'd1;
`endif
               // Lock wins over a timeout landing on the same word.
               if (any_hit && count_d == LOCK_CNT) begin
                  state_d = ST_LOCKED;
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
               end else if (tmo_d == TMO_LIM) begin
                  state_d = ST_ERROR;
`endif
               end
            end
         end
         ST_LOCKED, ST_ERROR: begin
         end
         default: state_d = ST_RESET;
      endcase
      if (in_align_reset) begin
         state_d  = ST_RESET;
         offset_d = '0;
         count_d  = '0;
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
         tmo_d    = '0;
`endif
      end
   end

   // Uses the offset being chosen this cycle so the locking word itself is emitted aligned.
   assign win_sel = 10'(win >> offset_d);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= ST_RESET;
         prev_q    <= '0;
         pattern_q <= '0;
         offset_q  <= '0;
         count_q   <= '0;
         m_data_q  <= '0;
         sv_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         offset_q  <= offset_d;
         count_q   <= count_d;
         sv_q      <= s_valid;
         done_q    <= (state_q == ST_LOCKED);
         if (s_valid) begin
            prev_q   <= s_data;
            m_data_q <= win_sel;
         end
      end
   end

`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= (state_q == ST_ERROR);
      end
   end
   assign out_align_error = error_q;
`else
   assign out_align_error = 1'b0;
`endif

   assign m_data         = m_data_q;
   assign m_valid        = sv_q && (state_q == ST_LOCKED);
   assign out_align_done = done_q;

endmodule

// File: tb/tb_rtcl_p3s7_word_align.sv
// Scoreboard bench for rtcl_p3s7_word_align: a word-level reference model predicts flags and aligned output.
module tb_rtcl_p3s7_word_align;

   localparam int LC = 4;
   localparam int TW = 100;
`ifdef RTCL_P3S7_WORD_ALIGN_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int MS_RESET = 0, MS_SEARCH = 1, MS_LOCK = 2, MS_ERR = 3;

   logic       aclk = 1'b0;
   logic       aresetn = 1'b0;
   logic       in_align_reset = 1'b1;
   logic [9:0] in_align_pattern = '0;
   logic [9:0] s_data = '0;
   logic       s_valid = 1'b0;
   logic [9:0] m_data, m_data1;
   logic       m_valid, m_valid1;
   logic       out_align_done, done1;
   logic       out_align_error, err1;

   int errors = 0;
   int checks = 0;
   logic [9:0] exp_q[$];

   int         md_st = MS_RESET;
   logic [9:0] md_prev = '0;
   logic [9:0] md_pat = '0;
   int         md_off = 0, md_cnt = 0, md_tmo = 0;
   bit         md_done = 0, md_err = 0;

   rtcl_p3s7_word_align #(.LOCK_COUNT(LC), .TIMEOUT_WORDS(TW)) u_dut (
      .aclk(aclk), .aresetn(aresetn), .in_align_reset(in_align_reset),
      .in_align_pattern(in_align_pattern), .s_data(s_data), .s_valid(s_valid),
      .m_data(m_data), .m_valid(m_valid),
      .out_align_done(out_align_done), .out_align_error(out_align_error));

   rtcl_p3s7_word_align #(.LOCK_COUNT(1), .TIMEOUT_WORDS(TW)) u_dut1 (
      .aclk(aclk), .aresetn(aresetn), .in_align_reset(in_align_reset),
      .in_align_pattern(in_align_pattern), .s_data(s_data), .s_valid(s_valid),
      .m_data(m_data1), .m_valid(m_valid1),
      .out_align_done(done1), .out_align_error(err1));

   always #5 aclk = ~aclk;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] rotl(logic [9:0] p, int k);
      return (p << k) | (p >> (10 - k));
   endfunction

   // Ten-bit view of {new word, previous word} starting at bit k.
   function automatic logic [9:0] cand(logic [9:0] d, logic [9:0] p, int k);
      logic [19:0] w;
      w = {d, p};
      return 10'((w >> k) & 20'h003ff);
   endfunction

   task automatic model_reset();
      md_st = MS_RESET; md_prev = '0; md_pat = '0;
      md_off = 0; md_cnt = 0; md_tmo = 0; md_done = 0; md_err = 0;
      exp_q.delete();
   endtask

   task automatic model_edge(bit rst, logic [9:0] pin, bit v, logic [9:0] d);
      int old;
      int lowest;
      old = md_st;
      md_done = (old == MS_LOCK);
      md_err  = (old == MS_ERR);
      if (rst) begin
         md_st = MS_RESET; md_off = 0; md_cnt = 0; md_tmo = 0;
      end else if (old == MS_RESET) begin
         md_pat = pin;
         md_st  = MS_SEARCH;
      end else if (old == MS_SEARCH && v) begin
         lowest = -1;
         for (int k = 9; k >= 0; k--)
            if (cand(d, md_prev, k) == md_pat) lowest = k;
         if (lowest >= 0 && cand(d, md_prev, md_off) == md_pat) md_cnt++;
         else if (lowest >= 0) begin
            md_off = lowest;
            md_cnt = 1;
         end else md_cnt = 0;
         md_tmo++;
         if (lowest >= 0 && md_cnt == LC) md_st = MS_LOCK;
         else if (TMO_EN && md_tmo == TW) md_st = MS_ERR;
      end
      if (v && md_st == MS_LOCK) exp_q.push_back(cand(d, md_prev, md_off));
      if (v) md_prev = d;
   endtask

   task automatic step(bit rst, logic [9:0] pin, bit v, logic [9:0] d);
      in_align_reset   = rst;
      in_align_pattern = pin;
      s_valid          = v;
      s_data           = d;
      @(posedge aclk);
      #1;
      model_edge(rst, pin, v, d);
      check("done", out_align_done, md_done);
      check("error", out_align_error, md_err);
   endtask

   task automatic async_reset_pulse();
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      check("async m_data", m_data, 0);
      check("async m_valid", m_valid, 0);
      check("async done", out_align_done, 0);
      check("async error", out_align_error, 0);
      model_reset();
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
   endtask

   always @(negedge aclk) begin
      if (aresetn) begin
         check("m_valid", m_valid, exp_q.size() != 0);
         if (m_valid && exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
         else if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   initial begin
      logic [9:0] p, w3, w7, pr, dr;
      int kk, r;
      bit rr, vr;
      p  = 10'h3a6;
      w3 = rotl(p, 3);
      w7 = rotl(p, 7);

      #12;
      check("reset m_data", m_data, 0);
      check("reset m_valid", m_valid, 0);
      check("reset done", out_align_done, 0);
      check("reset error", out_align_error, 0);
      check("reset error lc1", err1, 0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 3; i++) step(1, p, 0, 0);

      // Continuous stream matching at k=3
      step(1, p, 1, w3);
      step(0, p, 0, 0);
      step(0, p, 1, w3);
      check("lc1 m_valid", m_valid1, 1);
      check("lc1 m_data", m_data1, 10'h3a6);
      check("lc1 done early", done1, 0);
      step(0, p, 1, w3);
      check("lc1 done", done1, 1);
      step(0, p, 1, w3);
      step(0, p, 1, w3);
      check("s1 done before", out_align_done, 0);
      check("s1 m_valid", m_valid, 1);
      check("s1 m_data", m_data, 10'h3a6);
      step(0, p, 0, 0);
      check("s1 done", out_align_done, 1);

      // Two hits at k=3, garbage, then hits at k=7
      step(1, p, 1, w3);
      step(0, p, 0, 0);
      step(0, p, 1, w3);
      step(0, p, 1, w3);
      step(0, p, 1, 10'h000);
      for (int i = 0; i < 4; i++) step(0, p, 1, w7);
      check("s2 no early lock", out_align_done, 0);
      step(0, p, 1, w7);
      check("s2 m_data", m_data, 10'h3a6);
      step(0, p, 0, 0);
      check("s2 done", out_align_done, 1);

      // Valid toggling: idle cycles must not advance the count
      step(1, p, 1, w3);
      step(0, p, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, p, 1, w3);
         step(0, p, 0, 0);
      end
      step(0, p, 0, 0);
      check("s3 three words", out_align_done, 0);
      step(0, p, 1, w3);
      step(0, p, 0, 0);
      check("s3 four words", out_align_done, 1);

      // No pattern in stream: timeout after TW words only when enabled
      step(1, p, 1, 10'h000);
      step(0, p, 0, 0);
      for (int i = 0; i < TW - 1; i++) step(0, p, 1, ($urandom_range(0, 1) != 0) ? 10'h3ff : 10'h000);
      step(0, p, 0, 0);
      check("s4 error before", out_align_error, 0);
      step(0, p, 1, 10'h3ff);
      step(0, p, 0, 0);
      check("s4 error", out_align_error, TMO_EN);
      check("s4 done", out_align_done, 0);
      for (int i = 0; i < 5; i++) step(0, p, 1, w3);
      check("s4 error held", out_align_error, TMO_EN);

      // Relock on a new pattern after in_align_reset while locked
      step(1, p, 1, w3);
      step(0, p, 0, 0);
      for (int i = 0; i < 4; i++) step(0, p, 1, w3);
      step(0, p, 0, 0);
      check("s5 locked", out_align_done, 1);
      step(1, 10'h155, 1, 10'h155);
      check("s5 m_valid", m_valid, 0);
      step(0, 10'h155, 0, 0);
      check("s5 done drop", out_align_done, 0);
      for (int i = 0; i < 8; i++) step(0, p, 1, 10'h3a6);
      check("s5 old pattern ignored", out_align_done, 0);
      for (int i = 0; i < 6; i++) step(0, p, 1, 10'h155);
      step(0, p, 0, 0);
      check("s5 relock", out_align_done, 1);

      // Asynchronous reset while locked and mid-search
      async_reset_pulse();
      step(1, p, 1, w3);
      step(0, p, 0, 0);
      step(0, p, 1, w3);
      step(0, p, 1, 10'h2c1);
      async_reset_pulse();

      // Randomized traffic with occasional aligner clears and offset changes
      pr = 10'($urandom);
      kk = $urandom_range(0, 9);
      step(1, pr, 0, 0);
      for (int i = 0; i < 600; i++) begin
         r  = $urandom_range(0, 199);
         rr = (r < 3);
         if (rr) pr = 10'($urandom);
         if (r >= 3 && r < 6) kk = $urandom_range(0, 9);
         vr = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 9) < 8) ? rotl(pr, kk) : 10'($urandom);
         step(rr, pr, vr, dr);
      end
      step(0, pr, 0, 0);
      step(0, pr, 0, 0);
      check("queue drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
